lfsr_prng: RTL and testbench
============================

// Module: lfsr_prng
// PURPOSE
//  Parametrised Galois LFSR random-number generator: free-running WIDTH-bit state, seedable, lock-up safe.
//  Serves game logic (enemy spawn, AI turn choice, power-up drops) with a 2-stage registered raw stream
//  and a ready/valid "draw" port that returns a uniform value in [0, bound) by rejection sampling.
// PARAMETERS
//  WIDTH        32            LFSR state width (8..32)
//  TAPS         32'h80200003  Galois feedback mask, bit i = tap; must be maximal-length for WIDTH
//  SEED_DEFAULT 32'hACE1ACE1  reset/recovery seed [WIDTH-1:0]; must be nonzero
//  OUT_W        9             width of raw_out / rsp_data / req_bound (<= WIDTH)
//  MAX_TRIES    8             rejection attempts before fallback (>= 1)
// PORTS
//  Clk        in   1      clock
//  reset_n    in   1      asynchronous, active-low reset
//  enable     in   1      advance LFSR one step per cycle when 1
//  seed_load  in   1      load seed this cycle (priority over step)
//  seed       in   WIDTH  seed value
//  raw_out    out  OUT_W  state[OUT_W-1:0], 2-cycle registered
//  lockup     out  1      1-cycle pulse: zero seed replaced by SEED_DEFAULT
//  req_valid  in   1      draw request
//  req_ready  out  1      1 in IDLE only
//  req_bound  in   OUT_W  exclusive upper bound; 0 = full OUT_W range
//  rsp_valid  out  1      draw result valid, held until rsp_ready
//  rsp_ready  in   1      consumer accepts result
//  rsp_data   out  OUT_W  result, stable while rsp_valid
// BEHAVIOUR
//  - Reset: state=SEED_DEFAULT, raw pipe=0, lockup=0, FSM=IDLE, rsp_valid=0, rsp_data=0, tries=0.
//  - Step (enable=1, seed_load=0): lsb=state[0]; state <= (state>>1) ^ (lsb ? TAPS : 0).
//  - seed_load=1: state <= (seed==0) ? SEED_DEFAULT : seed; lockup=1 next cycle iff seed==0. No step that cycle.
//  - State never reaches 0; enable=0 holds state.
//  - raw_out: stage1<=state[OUT_W-1:0], stage2<=stage1 every cycle enable=1; raw_out=stage2 (latency 2).
//  - FSM IDLE->DRAW on req_valid&&req_ready; latch bound, tries=0. bound==0 -> IDLE->DONE directly,
//    rsp_data=state[OUT_W-1:0].
//  - mask = (bound-1) with all bits below its MSB set (bound=1 -> mask=0); cand = state[OUT_W-1:0] & mask.
//  - DRAW, per cycle with enable=1: cand<bound -> rsp_data=cand, DONE; else if tries==MAX_TRIES-1 ->
//    rsp_data=cand-bound (cand<2*bound so result<bound), DONE; else tries++. enable=0 stalls DRAW.
//  - DONE: rsp_valid=1; on rsp_ready -> IDLE next cycle (next req accepted one cycle later).
//  - seed_load during DRAW: seed applies, draw continues on new state. Reset mid-draw: IDLE, rsp_valid drops.
//  - All compares/subtracts unsigned OUT_W bits; no carry out.
// CONFIGURATION
//  LFSR_PRNG_STATS_EN defined: extra outputs stat_draws[15:0] (++ per rsp handshake) and stat_rejects[15:0]
//    (++ per rejected cand), both saturating at 16'hFFFF, cleared by reset_n only.
//  Undefined: those ports and counters do not exist; all other behaviour identical.
// STRUCTURE
//  lfsr_pkg: draw_state_e {IDLE,DRAW,DONE}; function lfsr_step(state,taps); function range_mask(bound).
//  Sub-module lfsr_core (state reg, step, seed/lock-up logic); lfsr_prng adds raw pipe, draw FSM, stats.
// TESTING (WIDTH=16, TAPS=16'hB400, SEED_DEFAULT=16'hACE1, OUT_W=9, MAX_TRIES=4)
//  1 reset, enable=1 one cycle -> state 16'hE270; period exactly 65535 steps, never 0.
//  2 seed_load=1 seed=0 -> state 16'hACE1, lockup pulses 1 cycle; seed=16'h0001 -> next step 16'hB400.
//  3 raw_out lags state[8:0] by 2 enabled cycles; enable=0 freezes state and raw_out.
//  4 1000 draws, bound=5 -> every rsp_data<5; bound=0 -> any 9-bit value; bound=1 -> always 0.
//  5 rsp_ready=0 for 10 cycles -> rsp_valid and rsp_data held, req_ready=0; force 4 rejects -> rsp=cand-bound.
//  6 reset_n low mid-DRAW -> rsp_valid=0, req_ready=1 after release; stats (if enabled) 0.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared types and helpers for the Galois LFSR random-number generator.
package lfsr_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DRAW,
    DONE
  } draw_state_e;

  // One Galois step; operands are zero-extended to 32 bits by the caller.
  function automatic logic [31:0] lfsr_step(input logic [31:0] state, input logic [31:0] taps);
    return (state >> 1) ^ (state[0] ? taps : 32'h0);
  endfunction

  // Smallest all-ones mask covering bound-1 (bound=1 gives 0).
  function automatic logic [31:0] range_mask(input logic [31:0] bound);
    logic [31:0] m;
    m = bound - 32'd1;
    m = m | (m >> 1);
    m = m | (m >> 2);
    m = m | (m >> 4);
    m = m | (m >> 8);
    m = m | (m >> 16);
    return m;
  endfunction

endpackage

// File: rtl/lfsr_core.sv
// LFSR state register with stepping, seed loading and zero-seed lock-up recovery.
module lfsr_core
  import lfsr_pkg::*;
#(
  parameter int unsigned WIDTH        = 32,
  parameter logic [31:0] TAPS         = 32'h80200003,
  parameter logic [31:0] SEED_DEFAULT = 32'hACE1ACE1,
  parameter int unsigned OUT_W        = 9
) (
  input  logic             Clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed,
  output logic [OUT_W-1:0] rnd,
  output logic             lockup
);

  localparam logic [WIDTH-1:0] SEED_W = WIDTH'(SEED_DEFAULT);

  logic [WIDTH-1:0] state_q;
  logic [WIDTH-1:0] state_d;
  logic             lockup_d;

  // Seed load wins over stepping; a zero seed would freeze the LFSR so it is replaced.
  always_comb begin
    state_d  = state_q;
    lockup_d = 1'b0;
    if (seed_load) begin
      if (seed == '0) begin
        state_d  = SEED_W;
        lockup_d = 1'b1;
      end else begin
        state_d = seed;
      end
    end else if (enable) begin
      state_d = WIDTH'(lfsr_step(32'(state_q), TAPS));
    end
  end

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= SEED_W;
      lockup  <= 1'b0;
    end else begin
      state_q <= state_d;
      lockup  <= lockup_d;
    end
  end

  assign rnd = state_q[OUT_W-1:0];

endmodule

// File: rtl/lfsr_prng.sv
// LFSR PRNG top: raw 2-stage stream plus a rejection-sampled bounded draw port.
// Optional usage counters when LFSR_PRNG_STATS_EN is defined.
module lfsr_prng
  import lfsr_pkg::*;
#(
  parameter int unsigned WIDTH        = 32,
  parameter logic [31:0] TAPS         = 32'h80200003,
  parameter logic [31:0] SEED_DEFAULT = 32'hACE1ACE1,
  parameter int unsigned OUT_W        = 9,
  parameter int unsigned MAX_TRIES    = 8
) (
  input  logic             Clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed,
  output logic [OUT_W-1:0] raw_out,
  output logic             lockup,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [OUT_W-1:0] req_bound,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [OUT_W-1:0] rsp_data
`ifdef LFSR_PRNG_STATS_EN
  ,
  output logic [15:0]      stat_draws,
  output logic [15:0]      stat_rejects
`endif
);

  localparam int unsigned TRIES_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
  localparam logic [TRIES_W-1:0] LAST_TRY = TRIES_W'(MAX_TRIES - 1);

  logic [OUT_W-1:0]   rnd;
  logic [OUT_W-1:0]   stage1;
  draw_state_e        st_q, st_d;
  logic [OUT_W-1:0]   bound_q, bound_d;
  logic [TRIES_W-1:0] tries_q, tries_d;
  logic [OUT_W-1:0]   rsp_data_d;
  logic               rsp_valid_d;
  logic               req_ready_d;
  logic [OUT_W-1:0]   mask_c;
  logic [OUT_W-1:0]   cand_c;
  logic               cand_ok_c;

  lfsr_core #(
    .WIDTH       (WIDTH),
    .TAPS        (TAPS),
    .SEED_DEFAULT(SEED_DEFAULT),
    .OUT_W       (OUT_W)
  ) u_core (
    .Clk      (Clk),
    .reset_n  (reset_n),
    .enable   (enable),
    .seed_load(seed_load),
    .seed     (seed),
    .rnd      (rnd),
    .lockup   (lockup)
  );

  // Raw stream advances only on enabled cycles so it stays aligned with the state.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      stage1  <= '0;
      raw_out <= '0;
    end else if (enable) begin
      stage1  <= rnd;
      raw_out <= stage1;
    end
  end

  assign mask_c    = OUT_W'(range_mask(32'(bound_q)));
  assign cand_c    = rnd & mask_c;
  assign cand_ok_c = cand_c < bound_q;

  // Draw FSM; cand < 2*bound always holds, so cand-bound is a safe fallback.
  always_comb begin
    st_d       = st_q;
    bound_d    = bound_q;
    tries_d    = tries_q;
    rsp_data_d = rsp_data;
    case (st_q)
      IDLE: begin
        if (req_valid) begin
          bound_d = req_bound;
          tries_d = '0;
          if (req_bound == '0) begin
            rsp_data_d = rnd;
            st_d       = DONE;
          end else begin
            st_d = DRAW;
          end
        end
      end
      DRAW: begin
        if (enable) begin
          if (cand_ok_c) begin
            rsp_data_d = cand_c;
            st_d       = DONE;
          end else if (tries_q == LAST_TRY) begin
            rsp_data_d = cand_c - bound_q;
            st_d       = DONE;
          end else begin
            tries_d = tries_q + TRIES_W'(1);
          end
        end
      end
      DONE: begin
        if (rsp_ready) st_d = IDLE;
      end
      default: st_d = IDLE;
    endcase
    rsp_valid_d = (st_d == DONE);
    req_ready_d = (st_d == IDLE);
  end

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      st_q      <= IDLE;
      bound_q   <= '0;
      tries_q   <= '0;
      rsp_data  <= '0;
      rsp_valid <= 1'b0;
      req_ready <= 1'b1;
    end else begin
      st_q      <= st_d;
      bound_q   <= bound_d;
      tries_q   <= tries_d;
      rsp_data  <= rsp_data_d;
      rsp_valid <= rsp_valid_d;
      req_ready <= req_ready_d;
    end
  end

`ifdef LFSR_PRNG_STATS_EN
  logic reject_c;
  assign reject_c = (st_q == DRAW) && enable && !cand_ok_c;

  // Saturating counters, cleared only by reset.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_draws   <= '0;
      stat_rejects <= '0;
    end else begin
      if (rsp_valid && rsp_ready && (stat_draws != 16'hFFFF))
        stat_draws <= stat_draws + 16'd1;
      if (reject_c && (stat_rejects != 16'hFFFF))
        stat_rejects <= stat_rejects + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_lfsr_prng.sv
// Self-checking bench for lfsr_prng (WIDTH=16, TAPS=16'hB400, OUT_W=9, MAX_TRIES=4).
module tb_lfsr_prng;

  localparam int          MT   = 4;
  localparam logic [15:0] SEED = 16'hACE1;
  localparam int          TAPV = 32'h0000B400;

  logic        Clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        seed_load = 1'b0;
  logic [15:0] seed = '0;
  logic [8:0]  raw_out;
  logic        lockup;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [8:0]  req_bound = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [8:0]  rsp_data;
`ifdef LFSR_PRNG_STATS_EN
  logic [15:0] stat_draws;
  logic [15:0] stat_rejects;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_on   = 1'b0;

  always #5 Clk = ~Clk;

  lfsr_prng #(
    .WIDTH       (16),
    .TAPS        (32'h0000B400),
    .SEED_DEFAULT(32'h0000ACE1),
    .OUT_W       (9),
    .MAX_TRIES   (MT)
  ) dut (
    .Clk      (Clk),
    .reset_n  (reset_n),
    .enable   (enable),
    .seed_load(seed_load),
    .seed     (seed),
    .raw_out  (raw_out),
    .lockup   (lockup),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_bound(req_bound),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data (rsp_data)
`ifdef LFSR_PRNG_STATS_EN
    ,
    .stat_draws  (stat_draws),
    .stat_rejects(stat_rejects)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference step written as integer arithmetic: halve, fold taps in when an odd value shifts out.
  function automatic int model_step(input int s);
    return (s / 2) ^ (((s % 2) == 1) ? TAPV : 0);
  endfunction

  // Expected draw result from the state at the accept edge (enable held high throughout).
  function automatic logic [8:0] predict(input logic [15:0] s0, input logic [8:0] b, output bit fell);
    int p, s, cand;
    fell = 1'b0;
    cand = 0;
    if (b == 9'd0) return s0[8:0];
    p = 1;
    while (p < int'(b)) p = p * 2;
    s = int'(s0);
    for (int k = 0; k < MT; k++) begin
      s = model_step(s);
      cand = (s % 512) % p;
      if (cand < int'(b)) return 9'(cand);
    end
    fell = 1'b1;
    return 9'(cand - int'(b));
  endfunction

  // Behavioural model of state, lock-up flag and the last two enabled-edge samples.
  logic [15:0] m_state;
  logic        m_lock;
  logic [8:0]  m_last, m_prev;

  always @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      m_state <= SEED;
      m_lock  <= 1'b0;
      m_last  <= '0;
      m_prev  <= '0;
    end else begin
      m_lock <= seed_load && (seed == 16'd0);
      if (seed_load) m_state <= (seed == 16'd0) ? SEED : seed;
      else if (enable) m_state <= 16'(model_step(int'(m_state)));
      if (enable) begin
        m_last <= m_state[8:0];
        m_prev <= m_last;
      end
    end
  end

  always @(negedge Clk) begin
    if (chk_on && reset_n) begin
      check("state_track", 32'(dut.u_core.state_q), 32'(m_state));
      check("raw_out_track", 32'(raw_out), 32'(m_prev));
      check("lockup_track", 32'(lockup), 32'(m_lock));
    end
  end

  // One draw: request, optional hold with rsp_ready low, then accept.
  task automatic draw(input logic [8:0] b, input int hold, output logic [8:0] got,
                      output int lat, output bit fell);
    int guard;
    logic [8:0] exp;
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(negedge Clk);
      guard++;
    end
    check("req_ready_wait", 32'(req_ready), 32'd1);
    exp = predict(m_state, b, fell);
    req_valid = 1'b1;
    req_bound = b;
    @(negedge Clk);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(negedge Clk);
      lat++;
    end
    check("rsp_valid_timeout", 32'(rsp_valid), 32'd1);
    check("rsp_data", 32'(rsp_data), 32'(exp));
    got = rsp_data;
    for (int i = 0; i < hold; i++) begin
      @(negedge Clk);
      check("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      check("hold_rsp_data", 32'(rsp_data), 32'(exp));
      check("hold_req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge Clk);
    rsp_ready = 1'b0;
  endtask

  typedef struct {
    logic [15:0] seed_v;
    logic [15:0] exp_load;
    bit          exp_lock;
    logic [15:0] exp_step;
  } seed_vec_t;

  initial begin
    seed_vec_t   vec[5];
    logic [8:0]  got;
    logic [15:0] s;
    logic [8:0]  raw_hold;
    int          lat, first_ret, zero_cnt;
    bit          fell;

    vec[0] = '{16'h0000, 16'hACE1, 1'b1, 16'hE270};
    vec[1] = '{16'h0001, 16'h0001, 1'b0, 16'hB400};
    vec[2] = '{16'hACE1, 16'hACE1, 1'b0, 16'hE270};
    vec[3] = '{16'h8000, 16'h8000, 1'b0, 16'h4000};
    vec[4] = '{16'hB400, 16'hB400, 1'b0, 16'h5A00};

    // Reset values
    repeat (3) @(negedge Clk);
    check("rst_raw_out", 32'(raw_out), 32'd0);
    check("rst_lockup", 32'(lockup), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_state", 32'(dut.u_core.state_q), 32'h0000ACE1);
    reset_n = 1'b1;
    @(negedge Clk);
    enable = 1'b1;
    @(negedge Clk);
    enable = 1'b0;
    check("first_step", 32'(dut.u_core.state_q), 32'h0000E270);
    chk_on = 1'b1;

    // Seed loads, including the zero-seed recovery
    foreach (vec[i]) begin
      seed_load = 1'b1;
      seed = vec[i].seed_v;
      enable = 1'b1;
      @(negedge Clk);
      seed_load = 1'b0;
      check("seed_load_state", 32'(dut.u_core.state_q), 32'(vec[i].exp_load));
      check("seed_load_lockup", 32'(lockup), 32'(vec[i].exp_lock));
      @(negedge Clk);
      check("seed_next_step", 32'(dut.u_core.state_q), 32'(vec[i].exp_step));
      check("lockup_one_cycle", 32'(lockup), 32'd0);
    end

    // Raw pipe under a random enable pattern, then a freeze
    for (int i = 0; i < 40; i++) begin
      enable = 1'($urandom_range(0, 1));
      @(negedge Clk);
    end
    enable = 1'b0;
    @(negedge Clk);
    s = dut.u_core.state_q;
    raw_hold = raw_out;
    check("pre_freeze_state", 32'(s), 32'(m_state));
    repeat (5) @(negedge Clk);
    check("freeze_state", 32'(dut.u_core.state_q), 32'(s));
    check("freeze_raw", 32'(raw_out), 32'(raw_hold));

    // Full period from the default seed
    seed_load = 1'b1;
    seed = SEED;
    @(negedge Clk);
    seed_load = 1'b0;
    enable = 1'b1;
    first_ret = 0;
    zero_cnt = 0;
    for (int i = 1; i <= 65535; i++) begin
      @(negedge Clk);
      if (dut.u_core.state_q == 16'd0) zero_cnt++;
      if (first_ret == 0 && dut.u_core.state_q == SEED) first_ret = i;
    end
    check("period", 32'(first_ret), 32'd65535);
    check("never_zero", 32'(zero_cnt), 32'd0);

    // Bounded draws
    for (int i = 0; i < 1000; i++) begin
      draw(9'd5, 0, got, lat, fell);
      check("bound5_range", 32'(got < 9'd5), 32'd1);
    end
    for (int i = 0; i < 200; i++) begin
      draw(9'd0, 0, got, lat, fell);
      check("bound0_latency", 32'(lat), 32'd1);
    end
    for (int i = 0; i < 100; i++) begin
      draw(9'd1, 0, got, lat, fell);
      check("bound1_zero", 32'(got), 32'd0);
    end
    for (int i = 0; i < 200; i++) begin
      logic [8:0] b;
      b = 9'($urandom_range(0, 511));
      draw(b, 0, got, lat, fell);
      if (b != 9'd0) check("rand_bound_range", 32'(got < b), 32'd1);
    end

    // Consumer back-pressure
    draw(9'd5, 10, got, lat, fell);

    // Forced fallback: pick a seed whose next MT candidates are all rejected
    do begin
      s = 16'($urandom_range(1, 65535));
      got = predict(s, 9'd257, fell);
    end while (!fell);
    seed_load = 1'b1;
    seed = s;
    @(negedge Clk);
    seed_load = 1'b0;
    draw(9'd257, 0, got, lat, fell);
    check("fallback_taken", 32'(fell), 32'd1);
    check("fallback_latency", 32'(lat), 32'(MT + 1));
    check("fallback_range", 32'(got < 9'd257), 32'd1);

    // Reset while a draw is stalled in DRAW
    enable = 1'b0;
    req_valid = 1'b1;
    req_bound = 9'd5;
    @(negedge Clk);
    req_valid = 1'b0;
    repeat (3) @(negedge Clk);
    check("stall_req_ready", 32'(req_ready), 32'd0);
    check("stall_rsp_valid", 32'(rsp_valid), 32'd0);
    #2 reset_n = 1'b0;
    #1 check("midreset_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge Clk);
    reset_n = 1'b1;
    @(negedge Clk);
    check("postreset_req_ready", 32'(req_ready), 32'd1);
    check("postreset_rsp_valid", 32'(rsp_valid), 32'd0);
`ifdef LFSR_PRNG_STATS_EN
    check("stat_draws_cleared", 32'(stat_draws), 32'd0);
    check("stat_rejects_cleared", 32'(stat_rejects), 32'd0);
`endif

    // Reset while a response is pending
    enable = 1'b1;
    req_valid = 1'b1;
    req_bound = 9'd0;
    @(negedge Clk);
    req_valid = 1'b0;
    check("pending_rsp_valid", 32'(rsp_valid), 32'd1);
    #2 reset_n = 1'b0;
    #1 check("pending_reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("pending_reset_rsp_data", 32'(rsp_data), 32'd0);
    @(negedge Clk);
    reset_n = 1'b1;
    @(negedge Clk);
    check("final_req_ready", 32'(req_ready), 32'd1);

    chk_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
